// File: rtl/bhargava_pkg.sv
// rtl/bhargava_pkg.sv - shared command type, FSM states and legality helpers for the advance arbiter
package bhargava_pkg;

  localparam logic [4:0] MAX_ADVANCE = 5'd16;

  typedef struct packed {
    logic [4:0] advance;
    logic       align;
    logic       extend;
    logic       lock;
  } adv_cmd_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    OWN0       = 3'd1,
    OWN1       = 3'd2,
    FLUSH      = 3'd3,
    FLUSH_WAIT = 3'd4
  } arb_state_t;

  // Extend wins over align; an extend always presents the full 16-bit advance.
  function automatic adv_cmd_t legalize(input adv_cmd_t c);
    adv_cmd_t r;
    r = c;
    if (c.extend) begin
      r.align   = 1'b0;
      r.advance = MAX_ADVANCE;
    end else if (c.advance > MAX_ADVANCE) begin
      r.advance = MAX_ADVANCE;
    end
    return r;
  endfunction

  function automatic logic cmd_illegal(input adv_cmd_t c);
    return (c.advance > MAX_ADVANCE) || (c.align && c.extend);
  endfunction

endpackage

// File: rtl/advance_credit_ctr.sv
// rtl/advance_credit_ctr.sv - downstream count-FIFO credit tracking with saturation and issue permit
module advance_credit_ctr #(
  parameter int CREDITS = 4,
  parameter int CRD_W   = $clog2(CREDITS + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic cnt_wr,
  input  logic fifo_pop,
  input  logic inflight,
  output logic permit,
  output logic err
);

  localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(CREDITS);

  logic [CRD_W-1:0] credits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits <= CRD_MAX;
    end else begin
      case ({cnt_wr, fifo_pop})
        2'b10:   if (credits != '0)      credits <= credits - 1'b1;
        2'b01:   if (credits != CRD_MAX) credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  assign err = (cnt_wr && !fifo_pop && credits == '0) ||
               (fifo_pop && !cnt_wr && credits == CRD_MAX);

  // A command on cnt_* this cycle will consume a credit that is not yet deducted.
  assign permit = credits > {{(CRD_W-1){1'b0}}, inflight};

endmodule

// File: rtl/advance_arbiter.sv
// rtl/advance_arbiter.sv - arbitrates parser and entropy-decoder commands onto the shared extend counter
module advance_arbiter
  import bhargava_pkg::*;
#(
  parameter  int CREDITS = 4,
  localparam int CRD_W   = $clog2(CREDITS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0][4:0] req_advance,
  input  logic [1:0]      req_align,
  input  logic [1:0]      req_extend,
  input  logic [1:0]      req_lock,
  input  logic            flush,
  output logic            flush_done,
  output logic            cnt_clk_en,
  output logic [4:0]      cnt_advance,
  output logic            cnt_align,
  output logic            cnt_extend_en,
  input  logic            cnt_wr,
  input  logic            fifo_pop,
  output logic            cmd_err
);

  arb_state_t state, state_nxt;
  logic       rr_ptr, rr_nxt;
  logic       flush_pend;
  logic       permit, credit_err;
  logic       win, take, issue_flush, cmd_bad;
  logic [1:0] ready;
  adv_cmd_t   cmd_in, cmd_out;

  advance_credit_ctr #(
    .CREDITS(CREDITS),
    .CRD_W  (CRD_W)
  ) u_credit (
    .clk     (clk),
    .rst     (rst),
    .cnt_wr  (cnt_wr),
    .fifo_pop(fifo_pop),
    .inflight(cnt_clk_en),
    .permit  (permit),
    .err     (credit_err)
  );

  assign cmd_in  = '{advance: req_advance[win], align: req_align[win],
                     extend: req_extend[win], lock: req_lock[win]};
  assign cmd_out = legalize(cmd_in);
  assign cmd_bad = cmd_illegal(cmd_in);

  assign req_ready = rst ? 2'b00 : ready;
  assign take      = |(req_ready & req_valid);

  always_comb begin
    ready       = 2'b00;
    state_nxt   = state;
    rr_nxt      = rr_ptr;
    win         = 1'b0;
    issue_flush = 1'b0;
    case (state)
      IDLE: begin
        if (flush_pend) begin
          state_nxt = FLUSH;
        end else if (|req_valid) begin
          // With both valid rr_ptr picks; otherwise the lone valid requester wins.
          win        = (req_valid == 2'b11) ? rr_ptr : req_valid[1];
          ready[win] = permit;
        end
      end
      OWN0: begin
        win      = 1'b0;
        ready[0] = permit;
      end
      OWN1: begin
        win      = 1'b1;
        ready[1] = permit;
      end
      FLUSH: begin
        if (permit) begin
          issue_flush = 1'b1;
          state_nxt   = FLUSH_WAIT;
        end
      end
      FLUSH_WAIT: state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
    if (take) begin
      if (cmd_out.lock) begin
        state_nxt = win ? OWN1 : OWN0;
      end else begin
        state_nxt = IDLE;
        rr_nxt    = ~win;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= 1'b0;
      flush_pend    <= 1'b0;
      flush_done    <= 1'b0;
      cnt_clk_en    <= 1'b0;
      cnt_advance   <= 5'd0;
      cnt_align     <= 1'b0;
      cnt_extend_en <= 1'b0;
      cmd_err       <= 1'b0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_nxt;
      // Leaving FLUSH absorbs any flush pulse arriving in the same cycle.
      if (issue_flush)  flush_pend <= 1'b0;
      else if (flush)   flush_pend <= 1'b1;
      flush_done    <= (state == FLUSH_WAIT);
      cnt_clk_en    <= take | issue_flush;
      cnt_advance   <= take ? cmd_out.advance : 5'd0;
      cnt_align     <= take ? cmd_out.align : issue_flush;
      cnt_extend_en <= take & cmd_out.extend;
      cmd_err       <= cmd_err | credit_err | (take & cmd_bad);
    end
  end

endmodule
